// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Turns a stream of PS/2 set-2 scancode bytes into one-cycle game commands.
//   It tracks E0 (extended), F0 (break) and E1 (pause) prefixes. It also keeps
//   a pressed-key bitmap, so typematic repeats do not re-trigger a command.
//   A partial prefix sequence is abandoned after TIMEOUT_CYCLES idle cycles.
//
// Ports
//   clk            system clock, rising edge
//   resetn         asynchronous active-low reset
//   ps2_byte       received scancode byte, meaningful only with ps2_byte_valid
//   ps2_byte_valid one-cycle strobe from the PS/2 receiver
//   move_right/left/up/down, enter
//                  one-cycle command pulses, at most one high per cycle
//   key_held       pressed state {enter,down,up,left,right}, bit0 = right
//   seq_error      one-cycle pulse when a prefix sequence times out
module ps2_key_decoder #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd1000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_valid,
  output logic       move_right,
  output logic       move_left,
  output logic       move_up,
  output logic       move_down,
  output logic       enter,
  output logic [4:0] key_held,
  output logic       seq_error
);

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    PAUSE_SKIP
  } stateT;

  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_PAUSE = 8'hE1;

  // Index into key_held / cmdPulse; KEY_NONE marks codes without a mapping.
  localparam logic [2:0] KEY_RIGHT = 3'd0;
  localparam logic [2:0] KEY_LEFT  = 3'd1;
  localparam logic [2:0] KEY_UP    = 3'd2;
  localparam logic [2:0] KEY_DOWN  = 3'd3;
  localparam logic [2:0] KEY_ENTER = 3'd4;
  localparam logic [2:0] KEY_NONE  = 3'd7;

  // The E1 pause sequence is E1 followed by seven more bytes.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  stateT       state;
  logic [2:0]  skipCnt;
  logic [19:0] timeoutCnt;
  logic [4:0]  cmdPulse;

  logic        doneMake;
  logic        doneBreak;
  logic        isExt;
  logic [2:0]  keyIdx;

  // Arrow keys exist only as extended codes. The plain codes with the same
  // values are keypad keys and are deliberately left unmapped.
  function automatic logic [2:0] mapKey(input logic ext, input logic [7:0] code);
    logic [2:0] idx;
    idx = KEY_NONE;
    if (ext) begin
      case (code)
        8'h74:   idx = KEY_RIGHT;
        8'h6B:   idx = KEY_LEFT;
        8'h75:   idx = KEY_UP;
        8'h72:   idx = KEY_DOWN;
        default: idx = KEY_NONE;
      endcase
    end else begin
      case (code)
        8'h5A, 8'h29: idx = KEY_ENTER;
        default:      idx = KEY_NONE;
      endcase
    end
    return idx;
  endfunction

  // Classify the byte being presented: does it complete a make or break code,
  // and is that code extended?
  // NOTE: every signal gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    doneMake  = 1'b0;
    doneBreak = 1'b0;
    isExt     = 1'b0;
    if (ps2_byte_valid) begin
      case (state)
        IDLE: begin
          if (ps2_byte != CODE_EXT && ps2_byte != CODE_BRK && ps2_byte != CODE_PAUSE)
            doneMake = 1'b1;
        end
        EXT: begin
          if (ps2_byte != CODE_BRK && ps2_byte != CODE_EXT) begin
            doneMake = 1'b1;
            isExt    = 1'b1;
          end
        end
        BRK:     doneBreak = 1'b1;
        EXT_BRK: begin
          doneBreak = 1'b1;
          isExt     = 1'b1;
        end
        default: ;
      endcase
    end
    keyIdx = mapKey(isExt, ps2_byte);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      skipCnt    <= 3'd0;
      timeoutCnt <= 20'd0;
      key_held   <= 5'b0;
      cmdPulse   <= 5'b0;
      seq_error  <= 1'b0;
    end else begin
      // Pulses are single-cycle unless re-asserted below.
      cmdPulse  <= 5'b0;
      seq_error <= 1'b0;

      if (ps2_byte_valid) begin
        // A byte always wins over a coincident timeout.
        timeoutCnt <= 20'd0;

        case (state)
          IDLE: begin
            if (ps2_byte == CODE_EXT)        state <= EXT;
            else if (ps2_byte == CODE_BRK)   state <= BRK;
            else if (ps2_byte == CODE_PAUSE) begin
              state   <= PAUSE_SKIP;
              skipCnt <= PAUSE_TAIL;
            end
          end
          EXT: begin
            if (ps2_byte == CODE_BRK)      state <= EXT_BRK;
            else if (ps2_byte != CODE_EXT) state <= IDLE;
          end
          BRK, EXT_BRK: state <= IDLE;
          PAUSE_SKIP: begin
            skipCnt <= skipCnt - 3'd1;
            if (skipCnt == 3'd1) state <= IDLE;
          end
          default: state <= IDLE;
        endcase

        if (keyIdx != KEY_NONE) begin
          // Only the first make of a key fires; typematic repeats just refresh.
          if (doneMake && !key_held[keyIdx]) begin
            cmdPulse[keyIdx] <= 1'b1;
            key_held[keyIdx] <= 1'b1;
          end
          if (doneBreak) key_held[keyIdx] <= 1'b0;
        end
      end else if (state != IDLE) begin
        if (timeoutCnt == TIMEOUT_CYCLES - 20'd1) begin
          state      <= IDLE;
          skipCnt    <= 3'd0;
          timeoutCnt <= 20'd0;
          seq_error  <= 1'b1;
        end else begin
          timeoutCnt <= timeoutCnt + 20'd1;
        end
      end else begin
        timeoutCnt <= 20'd0;
      end
    end
  end

  assign move_right = cmdPulse[KEY_RIGHT];
  assign move_left  = cmdPulse[KEY_LEFT];
  assign move_up    = cmdPulse[KEY_UP];
  assign move_down  = cmdPulse[KEY_DOWN];
  assign enter      = cmdPulse[KEY_ENTER];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
//   Directed scancode sequences. Each byte that should produce an output
//   pushes the expected {seq_error, enter, down, up, left, right} vector and
//   its expected cycle into a queue. A monitor on the falling edge pops an
//   entry whenever the DUT shows any output, and compares it.
module tb_ps2_key_decoder;

  logic       clk;
  logic       resetn;
  logic [7:0] ps2_byte;
  logic       ps2_byte_valid;
  logic       move_right, move_left, move_up, move_down, enter;
  logic [4:0] key_held;
  logic       seq_error;

  typedef struct {
    logic [5:0] val;
    int         cyc;
  } evtT;

  evtT q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;

  // Expected-event encodings: {seq_error, enter, down, up, left, right}
  localparam logic [5:0] E_NONE  = 6'b000000;
  localparam logic [5:0] E_RIGHT = 6'b000001;
  localparam logic [5:0] E_LEFT  = 6'b000010;
  localparam logic [5:0] E_UP    = 6'b000100;
  localparam logic [5:0] E_DOWN  = 6'b001000;
  localparam logic [5:0] E_ENTER = 6'b010000;
  localparam logic [5:0] E_SEQ   = 6'b100000;

  ps2_key_decoder #(.TIMEOUT_CYCLES(20'd16)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ps2_byte       (ps2_byte),
    .ps2_byte_valid (ps2_byte_valid),
    .move_right     (move_right),
    .move_left      (move_left),
    .move_up        (move_up),
    .move_down      (move_down),
    .enter          (enter),
    .key_held       (key_held),
    .seq_error      (seq_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle with an output present consumes one expected event.
  always @(negedge clk) begin
    logic [5:0] outs;
    evtT        e;
    outs = {seq_error, enter, move_down, move_up, move_left, move_right};
    if (!resetn) begin
      check("outputs_in_reset", {26'd0, outs}, 32'd0);
    end else if (outs != 6'd0) begin
      check("onehot_cmd", {31'd0, ($countones(outs[4:0]) <= 1)}, 32'd1);
      if (q.size() == 0) begin
        check("unexpected_output", {26'd0, outs}, 32'd0);
      end else begin
        e = q.pop_front();
        check("event_value", {26'd0, outs}, {26'd0, e.val});
        check("event_cycle", cyc, e.cyc);
      end
    end
  end

  // Drive one byte for one cycle. Called just after a rising edge; the byte
  // is sampled at the next edge, and any pulse is visible in that cycle.
  task automatic sendByte(input logic [7:0] b, input logic [5:0] expv);
    evtT e;
    if (expv != E_NONE) begin
      e.val = expv;
      e.cyc = cyc + 1;
      q.push_back(e);
    end
    ps2_byte       = b;
    ps2_byte_valid = 1'b1;
    @(posedge clk);
    #1;
    ps2_byte_valid = 1'b0;
    ps2_byte       = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] pauseSeq [8];
    pauseSeq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    resetn         = 1'b0;
    ps2_byte       = 8'h00;
    ps2_byte_valid = 1'b0;

    // Reset with strobes present: outputs must stay low.
    idle(2);
    ps2_byte       = 8'h5A;
    ps2_byte_valid = 1'b1;
    idle(3);
    ps2_byte_valid = 1'b0;
    check("held_in_reset", {27'd0, key_held}, 32'd0);
    #4 resetn = 1'b1;
    idle(2);
    check("held_after_reset", {27'd0, key_held}, 32'd0);

    // Extended right: press, then release.
    sendByte(8'hE0, E_NONE);
    sendByte(8'h74, E_RIGHT);
    check("held_right", {27'd0, key_held}, 32'b00001);
    sendByte(8'hE0, E_NONE);
    sendByte(8'hF0, E_NONE);
    sendByte(8'h74, E_NONE);
    check("held_right_released", {27'd0, key_held}, 32'd0);

    // Enter typematic, release, then the alternate space code.
    sendByte(8'h5A, E_ENTER);
    sendByte(8'h5A, E_NONE);
    sendByte(8'h5A, E_NONE);
    check("held_enter", {27'd0, key_held}, 32'b10000);
    sendByte(8'hF0, E_NONE);
    sendByte(8'h5A, E_NONE);
    check("held_enter_released", {27'd0, key_held}, 32'd0);
    sendByte(8'h29, E_ENTER);
    check("held_space", {27'd0, key_held}, 32'b10000);
    sendByte(8'h5A, E_NONE);
    sendByte(8'hF0, E_NONE);
    sendByte(8'h29, E_NONE);
    check("held_space_released", {27'd0, key_held}, 32'd0);

    // Pause sequence is swallowed whole, then extended up works.
    for (int i = 0; i < 8; i++) sendByte(pauseSeq[i], E_NONE);
    sendByte(8'hE0, E_NONE);
    sendByte(8'h75, E_UP);
    check("held_up", {27'd0, key_held}, 32'b00100);
    sendByte(8'hE0, E_NONE);
    sendByte(8'hF0, E_NONE);
    sendByte(8'h75, E_NONE);

    // Keypad/unmapped codes ignored; break of an unheld key is a no-op.
    sendByte(8'hE0, E_NONE);
    sendByte(8'h72, E_DOWN);
    sendByte(8'h72, E_NONE);
    sendByte(8'h1C, E_NONE);
    check("held_after_ignored", {27'd0, key_held}, 32'b01000);
    sendByte(8'hE0, E_NONE);
    sendByte(8'hF0, E_NONE);
    sendByte(8'h6B, E_NONE);
    check("held_unheld_break", {27'd0, key_held}, 32'b01000);
    sendByte(8'hE0, E_NONE);
    sendByte(8'h6B, E_LEFT);
    sendByte(8'hE0, E_NONE);
    sendByte(8'h6B, E_NONE);
    check("held_down_left", {27'd0, key_held}, 32'b01010);
    sendByte(8'hE0, E_NONE);
    sendByte(8'hF0, E_NONE);
    sendByte(8'h72, E_NONE);
    sendByte(8'hE0, E_NONE);
    sendByte(8'hF0, E_NONE);
    sendByte(8'h6B, E_NONE);
    check("held_cleared", {27'd0, key_held}, 32'd0);

    // Timeout: E0 then 16 idle cycles -> seq_error; 74 is then plain keypad.
    sendByte(8'hE0, E_NONE);
    begin
      evtT e;
      e.val = E_SEQ;
      e.cyc = cyc + 16;
      q.push_back(e);
    end
    idle(20);
    sendByte(8'h74, E_NONE);
    check("held_after_timeout", {27'd0, key_held}, 32'd0);

    // Byte arriving on the timeout cycle is processed in EXT, no seq_error.
    sendByte(8'hE0, E_NONE);
    idle(15);
    sendByte(8'h74, E_RIGHT);
    idle(20);
    check("held_coincident", {27'd0, key_held}, 32'b00001);
    sendByte(8'hE0, E_NONE);
    sendByte(8'hF0, E_NONE);
    sendByte(8'h74, E_NONE);

    // Reset mid-sequence: held bits drop at once, prefix is forgotten.
    sendByte(8'h5A, E_ENTER);
    sendByte(8'hE0, E_NONE);
    #3 resetn = 1'b0;
    #1 check("held_async_clear", {27'd0, key_held}, 32'd0);
    idle(2);
    #3 resetn = 1'b1;
    idle(1);
    sendByte(8'h74, E_NONE);
    sendByte(8'hE0, E_NONE);
    sendByte(8'h74, E_RIGHT);
    check("held_after_midreset", {27'd0, key_held}, 32'b00001);

    idle(4);
    check("events_outstanding", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
